// File: rtl/sr_ff_checker.sv
// rtl/sr_ff_checker.sv - cycle-accurate reference checker for an SR flip-flop DUV
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          synchronous active-low reset of the checker
//   en           check enable; the model keeps tracking while low
//   S, R         set/reset stimulus as applied to the DUV
//   duv_rst      DUV's own synchronous active-high reset as applied to the DUV
//   Q, Qbar      DUV outputs, one edge behind the stimulus that produced them
//   exp_q        model-predicted Q for the current cycle
//   exp_valid    model state is KNOWN (decoded straight from the state register)
//   mismatch     one-cycle pulse: Q differed from exp_q on the last compare
//   compl_err    one-cycle pulse: Qbar was not ~Q on the last compare
//   err_sticky   any error since checker reset
//   err_cnt      saturating count of erroring compares (at most one per edge)
//   illegal_cnt  saturating count of enabled edges sampling S=R=1 without duv_rst
//   check_cnt    saturating count of compares performed

module sr_ff_checker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             S,
    input  logic             R,
    input  logic             duv_rst,
    input  logic             Q,
    input  logic             Qbar,
    output logic             exp_q,
    output logic             exp_valid,
    output logic             mismatch,
    output logic             compl_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic [CNT_W-1:0] check_cnt
);

    typedef enum logic [1:0] {
        ST_UNINIT  = 2'd0,
        ST_KNOWN   = 2'd1,
        ST_UNKNOWN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state;

    logic comparing;
    logic q_bad;
    logic compl_bad;

    // Compare uses the state and prediction registered at the previous edge,
    // which lines up with the DUV's Q as it appears one edge later.
    assign comparing = en && (state == ST_KNOWN);
    assign q_bad     = (Q != exp_q);
    assign compl_bad = (Qbar == Q);
    assign exp_valid = (state == ST_KNOWN);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_UNINIT;
            exp_q       <= 1'b0;
            mismatch    <= 1'b0;
            compl_err   <= 1'b0;
            err_sticky  <= 1'b0;
            err_cnt     <= '0;
            illegal_cnt <= '0;
            check_cnt   <= '0;
        end else begin
            // Step 1: compare against the old prediction.
            mismatch  <= 1'b0;
            compl_err <= 1'b0;
            if (comparing) begin
                mismatch  <= q_bad;
                compl_err <= compl_bad;
                check_cnt <= sat_inc(check_cnt);
                if (q_bad || compl_bad) begin
                    err_cnt    <= sat_inc(err_cnt);
                    err_sticky <= 1'b1;
                end
            end

            // Step 2: predict from this edge's stimulus; independent of en so
            // re-enabling resumes checking with an up-to-date model.
            if (duv_rst) begin
                state <= ST_KNOWN;
                exp_q <= 1'b0;
            end else if (S && !R) begin
                state <= ST_KNOWN;
                exp_q <= 1'b1;
            end else if (!S && R) begin
                state <= ST_KNOWN;
                exp_q <= 1'b0;
            end else if (S && R) begin
                // exp_q is held; only the validity is lost.
                state <= ST_UNKNOWN;
                if (en) begin
                    illegal_cnt <= sat_inc(illegal_cnt);
                end
            end
        end
    end

endmodule

// File: tb/tb_sr_ff_checker.sv
// tb/tb_sr_ff_checker.sv - self-checking bench for sr_ff_checker

module tb_sr_ff_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, S, R, duv_rst, Q, Qbar;

    logic       a_exp_q, a_exp_valid, a_mismatch, a_compl_err, a_err_sticky;
    logic [7:0] a_err_cnt, a_illegal_cnt, a_check_cnt;
    logic       b_exp_q, b_exp_valid, b_mismatch, b_compl_err, b_err_sticky;
    logic [1:0] b_err_cnt, b_illegal_cnt, b_check_cnt;

    sr_ff_checker #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .S(S), .R(R), .duv_rst(duv_rst),
        .Q(Q), .Qbar(Qbar),
        .exp_q(a_exp_q), .exp_valid(a_exp_valid), .mismatch(a_mismatch),
        .compl_err(a_compl_err), .err_sticky(a_err_sticky),
        .err_cnt(a_err_cnt), .illegal_cnt(a_illegal_cnt), .check_cnt(a_check_cnt)
    );

    sr_ff_checker #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .S(S), .R(R), .duv_rst(duv_rst),
        .Q(Q), .Qbar(Qbar),
        .exp_q(b_exp_q), .exp_valid(b_exp_valid), .mismatch(b_mismatch),
        .compl_err(b_compl_err), .err_sticky(b_err_sticky),
        .err_cnt(b_err_cnt), .illegal_cnt(b_illegal_cnt), .check_cnt(b_check_cnt)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: "is the predicted value trustworthy" plus raw event
    // tallies; saturation is applied only when comparing to a counter width.
    bit m_valid, m_exp, m_mis, m_ce, m_sticky;
    int m_err, m_ill, m_chk;

    // Behaviour of a correct DUV, used to generate Q/Qbar.
    logic duv_q;

    localparam int F_NONE  = 0;  // correct DUV
    localparam int F_STUCK = 1;  // Q stuck at 0, Qbar consistent
    localparam int F_COMPL = 2;  // Qbar equals Q
    localparam int F_X     = 3;  // Q/Qbar undriven (only while model not valid)

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input bit exp);
        compared++;
        assert (obs === logic'(exp))
        else begin
            mismatched++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk_bit({tag, ".exp_valid"},   a_exp_valid,  m_valid);
        chk_bit({tag, ".exp_q"},       a_exp_q,      m_exp);
        chk_bit({tag, ".mismatch"},    a_mismatch,   m_mis);
        chk_bit({tag, ".compl_err"},   a_compl_err,  m_ce);
        chk_bit({tag, ".err_sticky"},  a_err_sticky, m_sticky);
        chk({tag, ".err_cnt"},     int'(a_err_cnt),     sat(m_err, 255));
        chk({tag, ".illegal_cnt"}, int'(a_illegal_cnt), sat(m_ill, 255));
        chk({tag, ".check_cnt"},   int'(a_check_cnt),   sat(m_chk, 255));
        chk_bit({tag, ".w2.exp_valid"}, b_exp_valid, m_valid);
        chk_bit({tag, ".w2.mismatch"},  b_mismatch,  m_mis);
        chk({tag, ".w2.err_cnt"},     int'(b_err_cnt),     sat(m_err, 3));
        chk({tag, ".w2.illegal_cnt"}, int'(b_illegal_cnt), sat(m_ill, 3));
        chk({tag, ".w2.check_cnt"},   int'(b_check_cnt),   sat(m_chk, 3));
    endtask

    // One clock: drive stimulus, clock it, advance models, check outputs.
    task automatic step(input string tag, input bit rn, input bit e, input bit s,
                        input bit r, input bit dr, input int fault);
        logic qd, qbd;
        @(negedge clk);
        rst = rn; en = e; S = s; R = r; duv_rst = dr;
        case (fault)
            F_STUCK: begin qd = 1'b0;  qbd = 1'b1;   end
            F_COMPL: begin qd = duv_q; qbd = duv_q;  end
            F_X:     begin qd = 1'bx;  qbd = 1'bx;   end
            default: begin qd = duv_q; qbd = ~duv_q; end
        endcase
        Q = qd; Qbar = qbd;
        @(posedge clk);

        if (!rn) begin
            m_valid = 0; m_exp = 0; m_mis = 0; m_ce = 0; m_sticky = 0;
            m_err = 0; m_ill = 0; m_chk = 0;
        end else begin
            if (e && m_valid) begin
                m_mis = (qd !== logic'(m_exp));
                m_ce  = (qbd === qd);
                m_chk++;
                if (m_mis || m_ce) begin
                    m_err++;
                    m_sticky = 1;
                end
            end else begin
                m_mis = 0;
                m_ce  = 0;
            end
            if (dr)          begin m_valid = 1; m_exp = 0; end
            else if (s && !r) begin m_valid = 1; m_exp = 1; end
            else if (r && !s) begin m_valid = 1; m_exp = 0; end
            else if (s && r)  begin m_valid = 0; if (e) m_ill++; end
        end

        if (dr)           duv_q = 1'b0;
        else if (s && !r) duv_q = 1'b1;
        else if (r && !s) duv_q = 1'b0;
        else if (s && r)  duv_q = 1'($urandom_range(0, 1));

        #1;
        check_outputs(tag);
    endtask

    initial begin
        rst = 0; en = 1; S = 0; R = 0; duv_rst = 0; Q = 0; Qbar = 1;
        duv_q = 1'($urandom_range(0, 1));
        m_valid = 0; m_exp = 0; m_mis = 0; m_ce = 0; m_sticky = 0;
        m_err = 0; m_ill = 0; m_chk = 0;

        // 1: reset, then duv_rst overriding S, then the first compare.
        step("rst0",  0, 1, 0, 0, 0, F_X);
        step("rst1",  0, 1, 0, 0, 0, F_X);
        step("duvrst", 1, 1, 1, 0, 1, F_X);
        step("first", 1, 1, 0, 0, 0, F_NONE);

        // 2: full S/R sweep with a correct DUV.
        step("sw00a", 1, 1, 0, 0, 0, F_NONE);
        step("sw01a", 1, 1, 0, 1, 0, F_NONE);
        step("sw10a", 1, 1, 1, 0, 0, F_NONE);
        step("sw11",  1, 1, 1, 1, 0, F_NONE);
        step("sw00b", 1, 1, 0, 0, 0, F_X);
        step("sw01b", 1, 1, 0, 1, 0, F_X);
        step("sw10b", 1, 1, 1, 0, 0, F_NONE);

        // 3: Q stuck at 0 after a set; sticky survives later clean cycles.
        step("set",   1, 1, 1, 0, 0, F_NONE);
        step("stuck", 1, 1, 0, 0, 0, F_STUCK);
        step("clean1", 1, 1, 0, 0, 0, F_NONE);
        step("clean2", 1, 1, 0, 1, 0, F_NONE);

        // 4: Qbar == Q in a known cycle.
        step("compl", 1, 1, 0, 0, 0, F_COMPL);
        step("after", 1, 1, 0, 0, 0, F_NONE);

        // 5: illegal saturation on the narrow instance, then mid-run reset.
        for (int i = 0; i < 5; i++) step("ill", 1, 1, 1, 1, 0, F_NONE);
        step("midrst", 0, 1, 1, 1, 0, F_NONE);
        step("postrst", 1, 1, 0, 0, 0, F_X);
        step("duvrst11", 1, 1, 1, 1, 1, F_X);

        // 6: model tracks while disabled.
        step("dis_set", 1, 0, 1, 0, 0, F_NONE);
        step("dis_hold", 1, 0, 0, 0, 0, F_NONE);
        step("reen", 1, 1, 0, 0, 0, F_NONE);

        // Random stimulus with occasional faults and resets.
        for (int i = 0; i < 400; i++) begin
            bit rn, e, s, r, dr;
            int f, pick;
            rn = ($urandom_range(0, 39) != 0);
            e  = ($urandom_range(0, 4) != 0);
            s  = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            dr = ($urandom_range(0, 9) == 0);
            pick = $urandom_range(0, 9);
            if (!m_valid && pick < 3) f = F_X;
            else if (pick == 8)      f = F_STUCK;
            else if (pick == 9)      f = F_COMPL;
            else                     f = F_NONE;
            step("rand", rn, e, s, r, dr, f);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
